// File: rtl/vrf_pkg.sv
`default_nettype none
// ============================================================================
//  vrf_pkg : shared widths and record types for VRF bank read traffic
//  Revision: 1.0
// ============================================================================
package vrf_pkg;

    localparam int VS_W       = 5;
    localparam int OFFSET_W   = 3;
    localparam int INST_IDX_W = 3;

    // Widest source tag any read-port client may need (up to 16 requesters).
    localparam int SRC_MAX_W  = 4;

    typedef struct packed {
        logic [VS_W-1:0]       vs;
        logic [OFFSET_W-1:0]   offset;
        logic [INST_IDX_W-1:0] instructionIndex;
    } vrf_read_req_t;

    typedef struct packed {
        logic                  valid;
        logic [SRC_MAX_W-1:0]  src;
        logic [INST_IDX_W-1:0] instructionIndex;
    } vrf_read_tag_t;

endpackage
`default_nettype wire

// File: rtl/vrf_read_port_scheduler_if.sv
`default_nettype none
// ============================================================================
//  vrf_read_port_scheduler_if : requester, bank-command and response bundle
//  Revision: 1.0
// ============================================================================
interface vrf_read_port_scheduler_if #(
    parameter int REQ_NUM = 4,
    parameter int DATA_W  = 32,
    parameter int SRC_W   = $clog2(REQ_NUM)
);
    logic [REQ_NUM-1:0]                      req_valid;
    logic [REQ_NUM-1:0]                      req_ready;
    logic [REQ_NUM*vrf_pkg::VS_W-1:0]        req_vs;
    logic [REQ_NUM*vrf_pkg::OFFSET_W-1:0]    req_offset;
    logic [REQ_NUM*vrf_pkg::INST_IDX_W-1:0]  req_instructionIndex;
    logic                                    write_busy;
    logic                                    vrf_read_valid;
    logic                                    vrf_read_ready;
    logic [vrf_pkg::VS_W-1:0]                vrf_read_vs;
    logic [vrf_pkg::OFFSET_W-1:0]            vrf_read_offset;
    logic [SRC_W-1:0]                        vrf_read_readSource;
    logic [vrf_pkg::INST_IDX_W-1:0]          vrf_read_instructionIndex;
    logic [DATA_W-1:0]                       vrf_rdata;
    logic [REQ_NUM-1:0]                      resp_valid;
    logic [DATA_W-1:0]                       resp_data;
    logic [vrf_pkg::INST_IDX_W-1:0]          resp_instructionIndex;

    // master: the scheduler itself; slave: requesters plus bank model
    modport master (
        input  req_valid, req_vs, req_offset, req_instructionIndex,
        input  write_busy, vrf_read_ready, vrf_rdata,
        output req_ready, vrf_read_valid, vrf_read_vs, vrf_read_offset,
        output vrf_read_readSource, vrf_read_instructionIndex,
        output resp_valid, resp_data, resp_instructionIndex
    );

    modport slave (
        output req_valid, req_vs, req_offset, req_instructionIndex,
        output write_busy, vrf_read_ready, vrf_rdata,
        input  req_ready, vrf_read_valid, vrf_read_vs, vrf_read_offset,
        input  vrf_read_readSource, vrf_read_instructionIndex,
        input  resp_valid, resp_data, resp_instructionIndex
    );

endinterface
`default_nettype wire

// File: rtl/vrf_read_port_scheduler_rr_grant.sv
`default_nettype none
// ============================================================================
//  rr_grant_onehot : round-robin pick, searched upward from prio_ptr, wrapping
//  Revision: 1.0
// ============================================================================
module rr_grant_onehot #(
    parameter int REQ_NUM = 4,
    parameter int SRC_W   = $clog2(REQ_NUM)
) (
    input  logic [REQ_NUM-1:0] valid,
    input  logic [SRC_W-1:0]   prio_ptr,
    output logic [REQ_NUM-1:0] grant,
    output logic [SRC_W-1:0]   grant_idx,
    output logic               any
);

    logic [SRC_W:0] idx;
    logic           found;

    // One extra bit holds prio_ptr+k before the explicit wrap, so REQ_NUM
    // need not be a power of two.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int k = 0; k < REQ_NUM; k++) begin
            idx = {1'b0, prio_ptr} + (SRC_W+1)'(k);
            if (idx >= (SRC_W+1)'(REQ_NUM)) begin
                idx = idx - (SRC_W+1)'(REQ_NUM);
            end
            if (!found && valid[idx[SRC_W-1:0]]) begin
                found                    = 1'b1;
                grant[idx[SRC_W-1:0]]    = 1'b1;
                grant_idx                = idx[SRC_W-1:0];
            end
        end
    end

    assign any = |valid;

endmodule
`default_nettype wire

// File: rtl/vrf_read_port_scheduler.sv
`default_nettype none
// ============================================================================
//  vrf_read_port_scheduler : round-robin sharing of one VRF bank read port,
//  with tagged fixed-latency response routing. Optional starvation guard
//  enabled by defining VRF_READ_STARVE_GUARD_EN.
//  Revision: 1.0
// ============================================================================
module vrf_read_port_scheduler
    import vrf_pkg::*;
#(
    parameter int REQ_NUM      = 4,
    parameter int SRC_W        = $clog2(REQ_NUM),
    parameter int READ_LATENCY = 2,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    vrf_read_port_scheduler_if.master bus
);

    localparam int REQ_BITS = $bits(vrf_read_req_t);

    if (READ_LATENCY < 1 || STARVE_LIMIT < 1 || REQ_NUM < 2 || REQ_NUM > 16) begin : g_param_check
        $error("vrf_read_port_scheduler: illegal parameter set");
    end

    logic                 issue_en;
    logic                 fire;
    logic [REQ_NUM-1:0]   rr_grant;
    logic [SRC_W-1:0]     rr_idx;
    logic                 rr_any;
    logic [REQ_NUM-1:0]   grant;
    logic [SRC_W-1:0]     grant_idx;
    logic [REQ_NUM-1:0]   req_ready;
    logic [SRC_W-1:0]     prio_ptr_q;
    logic [SRC_W-1:0]     prio_ptr_d;
    vrf_read_req_t        req [REQ_NUM];
    logic [REQ_BITS-1:0]  cmd_bits;
    vrf_read_req_t        cmd;
    vrf_read_tag_t        tag_q [READ_LATENCY];
    vrf_read_tag_t        tag_d [READ_LATENCY];
    vrf_read_tag_t        tag_out;
    logic [REQ_NUM-1:0]   resp_onehot;

    assign issue_en = ~bus.write_busy;

    always_comb begin
        for (int i = 0; i < REQ_NUM; i++) begin
            req[i].vs               = bus.req_vs[VS_W*i +: VS_W];
            req[i].offset           = bus.req_offset[OFFSET_W*i +: OFFSET_W];
            req[i].instructionIndex = bus.req_instructionIndex[INST_IDX_W*i +: INST_IDX_W];
        end
    end

    rr_grant_onehot #(
        .REQ_NUM (REQ_NUM),
        .SRC_W   (SRC_W)
    ) u_rr (
        .valid     (bus.req_valid),
        .prio_ptr  (prio_ptr_q),
        .grant     (rr_grant),
        .grant_idx (rr_idx),
        .any       (rr_any)
    );

`ifdef VRF_READ_STARVE_GUARD_EN
    localparam int               CNT_W     = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] wait_cnt_q [REQ_NUM];
    logic [CNT_W-1:0] wait_cnt_d [REQ_NUM];

    // Downward scan so the lowest starved index is the one left standing.
    always_comb begin
        grant     = rr_grant;
        grant_idx = rr_idx;
        for (int i = REQ_NUM - 1; i >= 0; i--) begin
            if (bus.req_valid[i] && (wait_cnt_q[i] >= CNT_LIMIT)) begin
                grant     = '0;
                grant[i]  = 1'b1;
                grant_idx = SRC_W'(i);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < REQ_NUM; i++) begin
            wait_cnt_d[i] = wait_cnt_q[i];
            if (!bus.req_valid[i] || req_ready[i]) begin
                wait_cnt_d[i] = '0;
            end else if (issue_en && (wait_cnt_q[i] != '1)) begin
                wait_cnt_d[i] = wait_cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < REQ_NUM; i++) begin
            if (reset) begin
                wait_cnt_q[i] <= '0;
            end else begin
                wait_cnt_q[i] <= wait_cnt_d[i];
            end
        end
    end
`else
    assign grant     = rr_grant;
    assign grant_idx = rr_idx;
`endif

    // AND-OR mux: a zero grant vector yields all-zero command fields.
    always_comb begin
        cmd_bits = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            cmd_bits = cmd_bits | (req[i] & {REQ_BITS{grant[i]}});
        end
    end
    assign cmd = vrf_read_req_t'(cmd_bits);

    assign bus.vrf_read_valid            = issue_en & rr_any;
    assign bus.vrf_read_vs               = cmd.vs;
    assign bus.vrf_read_offset           = cmd.offset;
    assign bus.vrf_read_instructionIndex = cmd.instructionIndex;
    assign bus.vrf_read_readSource       = grant_idx;

    assign req_ready     = grant & {REQ_NUM{issue_en & bus.vrf_read_ready}};
    assign bus.req_ready = req_ready;
    assign fire          = bus.vrf_read_valid & bus.vrf_read_ready;

    always_comb begin
        prio_ptr_d = prio_ptr_q;
        if (fire) begin
            prio_ptr_d = (grant_idx == SRC_W'(REQ_NUM - 1)) ? '0 : grant_idx + SRC_W'(1);
        end
    end

    always_comb begin
        tag_d[0] = '0;
        if (fire) begin
            tag_d[0].valid            = 1'b1;
            tag_d[0].src              = SRC_MAX_W'(grant_idx);
            tag_d[0].instructionIndex = cmd.instructionIndex;
        end
        for (int s = 1; s < READ_LATENCY; s++) begin
            tag_d[s] = tag_q[s-1];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            prio_ptr_q <= '0;
            for (int s = 0; s < READ_LATENCY; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            prio_ptr_q <= prio_ptr_d;
            for (int s = 0; s < READ_LATENCY; s++) begin
                tag_q[s] <= tag_d[s];
            end
        end
    end

    assign tag_out = tag_q[READ_LATENCY-1];

    always_comb begin
        resp_onehot = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            resp_onehot[i] = tag_out.valid && (tag_out.src == SRC_MAX_W'(i));
        end
    end

    assign bus.resp_valid            = resp_onehot;
    assign bus.resp_instructionIndex = tag_out.instructionIndex;
    assign bus.resp_data             = bus.vrf_rdata;

endmodule
`default_nettype wire

// File: tb/tb_vrf_read_port_scheduler.sv
`default_nettype none
// ============================================================================
//  tb_vrf_read_port_scheduler : scenario tasks plus a response scoreboard
//  Revision: 1.0
// ============================================================================
module tb_vrf_read_port_scheduler;
    import vrf_pkg::*;

    localparam int REQ_NUM      = 4;
    localparam int SRC_W        = 2;
    localparam int LAT          = 2;
    localparam int DATA_W       = 32;
    localparam int STARVE_LIMIT = 2;
    localparam int REQ3         = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;
    bit   mon_en = 1'b0;

    typedef struct {
        int         src;
        logic [2:0] inst;
        int         due;
    } exp_t;
    exp_t exp_q[$];

    vrf_read_port_scheduler_if #(.REQ_NUM(REQ_NUM), .DATA_W(DATA_W)) bus4 ();
    vrf_read_port_scheduler_if #(.REQ_NUM(REQ3),    .DATA_W(DATA_W)) bus3 ();

    vrf_read_port_scheduler #(
        .REQ_NUM(REQ_NUM), .READ_LATENCY(LAT), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT)
    ) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus4)
    );

    vrf_read_port_scheduler #(
        .REQ_NUM(REQ3), .READ_LATENCY(LAT), .DATA_W(DATA_W)
    ) u_dut3 (
        .clock (clock),
        .reset (reset),
        .bus   (bus3)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    assign bus4.vrf_rdata = 32'hDA7A_0000 | (cyc & 32'h0000_FFFF);
    assign bus3.vrf_rdata = '0;

    function automatic logic [4:0] exp_vs(int i);   return 5'(i * 7 + 3); endfunction
    function automatic logic [2:0] exp_off(int i);  return 3'(i + 1);     endfunction
    function automatic logic [2:0] exp_inst(int i); return 3'(i + 2);     endfunction

    // Response scoreboard: every cycle either pops the item due now or
    // requires an idle response bus.
    always @(negedge clock) begin
        if (mon_en && !reset) begin
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                exp_t e;
                e = exp_q.pop_front();
                checks++;
                if (bus4.resp_valid !== 4'(1 << e.src) || bus4.resp_instructionIndex !== e.inst ||
                    bus4.resp_data !== (32'hDA7A_0000 | (cyc & 32'h0000_FFFF))) begin
                    errors++;
                    $display("FAIL resp cyc=%0d: got valid=%b inst=%0d data=%h, want valid=%b inst=%0d data=%h",
                             cyc, bus4.resp_valid, bus4.resp_instructionIndex, bus4.resp_data,
                             4'(1 << e.src), e.inst, 32'hDA7A_0000 | (cyc & 32'h0000_FFFF));
                end
            end else begin
                checks++;
                if (bus4.resp_valid !== 4'b0000) begin
                    errors++;
                    $display("FAIL resp_unexpected cyc=%0d: got valid=%b, want 0000", cyc, bus4.resp_valid);
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive4(input logic [3:0] v, input logic busy, input logic rdy);
        bus4.req_valid      = v;
        bus4.write_busy     = busy;
        bus4.vrf_read_ready = rdy;
    endtask

    task automatic init_fields();
        for (int i = 0; i < REQ_NUM; i++) begin
            bus4.req_vs[5*i +: 5]               = exp_vs(i);
            bus4.req_offset[3*i +: 3]           = exp_off(i);
            bus4.req_instructionIndex[3*i +: 3] = exp_inst(i);
        end
        for (int i = 0; i < REQ3; i++) begin
            bus3.req_vs[5*i +: 5]               = exp_vs(i);
            bus3.req_offset[3*i +: 3]           = exp_off(i);
            bus3.req_instructionIndex[3*i +: 3] = exp_inst(i);
        end
        drive4(4'b0000, 1'b0, 1'b1);
        bus3.req_valid      = '0;
        bus3.write_busy     = 1'b0;
        bus3.vrf_read_ready = 1'b1;
    endtask

    // Expect a fire of requester s this cycle; checks command and queues response.
    task automatic expect_fire(input int s, input string tag);
        @(negedge clock);
        checks++;
        if (bus4.vrf_read_valid !== 1'b1 || bus4.vrf_read_readSource !== SRC_W'(s) ||
            bus4.req_ready !== 4'(1 << s)) begin
            errors++;
            $display("FAIL %s_grant cyc=%0d: got valid=%b src=%0d ready=%b, want valid=1 src=%0d ready=%b",
                     tag, cyc, bus4.vrf_read_valid, bus4.vrf_read_readSource, bus4.req_ready, s, 4'(1 << s));
        end
        checks++;
        if (bus4.vrf_read_vs !== exp_vs(s) || bus4.vrf_read_offset !== exp_off(s) ||
            bus4.vrf_read_instructionIndex !== exp_inst(s)) begin
            errors++;
            $display("FAIL %s_fields cyc=%0d: got vs=%0d off=%0d inst=%0d, want vs=%0d off=%0d inst=%0d",
                     tag, cyc, bus4.vrf_read_vs, bus4.vrf_read_offset, bus4.vrf_read_instructionIndex,
                     exp_vs(s), exp_off(s), exp_inst(s));
        end
        exp_q.push_back('{s, exp_inst(s), cyc + LAT});
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        init_fields();
        repeat (3) step();
        @(negedge clock);
        checks++;
        if (bus4.resp_valid !== 4'b0000 || bus3.resp_valid !== 3'b000) begin
            errors++;
            $display("FAIL reset_resp: got %b/%b, want 0000/000", bus4.resp_valid, bus3.resp_valid);
        end
        checks++;
        if (bus4.vrf_read_valid !== 1'b0 || bus4.req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_cmd: got valid=%b ready=%b, want 0/0000", bus4.vrf_read_valid, bus4.req_ready);
        end
        step();
        reset  = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic test_round_robin();
        drive4(4'b1111, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            expect_fire(k % 4, "rr");
        end
        drive4(4'b0000, 1'b0, 1'b1);
        repeat (3) step();
    endtask

    task automatic test_write_busy();
        reset = 1'b1;
        step();
        reset = 1'b0;
        drive4(4'b0101, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            checks++;
            if (bus4.req_ready !== 4'b0000 || bus4.vrf_read_valid !== 1'b0) begin
                errors++;
                $display("FAIL busy_stall cyc=%0d: got ready=%b valid=%b, want 0000/0",
                         cyc, bus4.req_ready, bus4.vrf_read_valid);
            end
            step();
        end
        drive4(4'b0101, 1'b0, 1'b1);
        expect_fire(0, "busy_after");
        expect_fire(2, "busy_after");
        drive4(4'b0000, 1'b0, 1'b1);
        repeat (3) step();
    endtask

    task automatic test_ready_stall();
        drive4(4'b0010, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            checks++;
            if (bus4.vrf_read_valid !== 1'b1 || bus4.vrf_read_readSource !== 2'd1 ||
                bus4.vrf_read_vs !== exp_vs(1) || bus4.req_ready !== 4'b0000) begin
                errors++;
                $display("FAIL stall_hold cyc=%0d: got valid=%b src=%0d vs=%0d ready=%b, want 1/1/%0d/0000",
                         cyc, bus4.vrf_read_valid, bus4.vrf_read_readSource, bus4.vrf_read_vs,
                         bus4.req_ready, exp_vs(1));
            end
            step();
        end
        drive4(4'b0010, 1'b0, 1'b1);
        expect_fire(1, "stall_release");
        drive4(4'b0000, 1'b0, 1'b1);
        repeat (3) step();
    endtask

    task automatic test_reset_drop();
        drive4(4'b1000, 1'b0, 1'b1);
        @(negedge clock);
        checks++;
        if (bus4.vrf_read_readSource !== 2'd3 || bus4.vrf_read_instructionIndex !== 3'd5 ||
            bus4.req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL drop_fire: got src=%0d inst=%0d ready=%b, want 3/5/1000",
                     bus4.vrf_read_readSource, bus4.vrf_read_instructionIndex, bus4.req_ready);
        end
        step();
        reset = 1'b1;
        drive4(4'b0000, 1'b0, 1'b1);
        step();
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (bus4.resp_valid !== 4'b0000) begin
            errors++;
            $display("FAIL drop_resp: got %b, want 0000", bus4.resp_valid);
        end
        step();
        step();
        drive4(4'b1111, 1'b0, 1'b1);
        expect_fire(0, "post_reset");
        drive4(4'b0000, 1'b0, 1'b1);
        repeat (3) step();
    endtask

    task automatic test_three();
        bus3.req_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            checks++;
            if (bus3.vrf_read_readSource !== 2'(k % 3) || bus3.req_ready !== 3'(1 << (k % 3))) begin
                errors++;
                $display("FAIL three_wrap k=%0d: got src=%0d ready=%b, want %0d/%b",
                         k, bus3.vrf_read_readSource, bus3.req_ready, k % 3, 3'(1 << (k % 3)));
            end
            step();
        end
        bus3.req_valid = 3'b000;
        step();
    endtask

    task automatic test_starve();
        int exp_src;
`ifdef VRF_READ_STARVE_GUARD_EN
        exp_src = 1;
`else
        exp_src = 0;
`endif
        drive4(4'b0010, 1'b0, 1'b1);
        expect_fire(1, "starve_setup");
        drive4(4'b0110, 1'b0, 1'b1);
        expect_fire(2, "starve_lose1");
        drive4(4'b1010, 1'b0, 1'b1);
        expect_fire(3, "starve_lose2");
        drive4(4'b0011, 1'b0, 1'b1);
        expect_fire(exp_src, "starve_pick");
        drive4(4'b0000, 1'b0, 1'b1);
        repeat (4) step();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_write_busy();
        test_ready_stall();
        test_reset_drop();
        test_three();
        test_starve();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d pending, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
